uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx serializer among NREQ byte-stream requesters (Fibonacci result
//  printer, status reporter, debug dumps). Round-robin arbitration with per-message
//  lock: once granted, a requester keeps the line until the byte flagged 'last' is sent.
//  Drives tx_start/din of uart_tx and sequences on its tx_done_tick.
// PARAMETERS
//  NREQ      4    number of requesters (2..8)
//  HOLD_MAX  255  clk cycles a granted requester may idle mid-message before abort
// PORTS
//  clk           in   1        system clock
//  reset         in   1        asynchronous, active-high
//  req           in   NREQ     req[i]: requester i presents a valid byte
//  req_data      in   8*NREQ   byte of requester i at [8*i+7:8*i]
//  req_last      in   NREQ     byte of requester i is the final byte of its message
//  ack           out  NREQ     1-cycle pulse: byte of requester i accepted (pop it)
//  grant         out  NREQ     one-hot, requester currently owning the line
//  busy          out  1        any grant active
//  abort         out  1        1-cycle pulse: locked message abandoned (hold timeout)
//  tx_start      out  1        to uart_tx.tx_start, 1-cycle pulse
//  tx_din        out  8        to uart_tx.din, stable from tx_start until done
//  tx_done_tick  in   1        from uart_tx.tx_done_tick
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer 0, grant/ack/busy/abort/tx_start = 0, tx_din = 0.
//    All outputs are registers or decodes of registered state; no comb path req->tx.
//  - States: IDLE, SEND, WAIT, HOLD.
//  - IDLE: if |req, pick first set req[k] scanning k = ptr, ptr+1, ... mod NREQ; latch
//    idx=k, tx_din=req_data[k], last_r=req_last[k]; grant[k]<=1; -> SEND. Else stay.
//  - SEND (exactly 1 cycle): tx_start=1, ack[idx]=1; -> WAIT. Latency req->tx_start = 1 clk.
//  - WAIT: ignore req. On tx_done_tick:
//      last_r=1 -> grant<=0, ptr<=(idx+1) mod NREQ, -> IDLE (next arbitration follows).
//      last_r=0 and req[idx]=1 -> latch req_data[idx]/req_last[idx], -> SEND.
//      last_r=0 and req[idx]=0 -> clear hold counter, -> HOLD.
//    tx_start is thus never issued earlier than 1 clk after tx_done_tick, when uart_tx is idle.
//  - HOLD: grant kept. req[idx]=1 -> latch byte, -> SEND. Else hold counter +1; when it
//    reaches HOLD_MAX: abort=1 (1 cycle), grant<=0, ptr<=idx+1, -> IDLE.
//  - Other requesters never preempt a locked message; requests from others stay pending.
//  - tx_done_tick outside WAIT is ignored. ack only in SEND, only to idx.
//  - ptr wraps NREQ-1 -> 0; counter width $clog2(HOLD_MAX+1), saturating not required.
//  - Reset mid-message: immediate return to reset values; uart_tx shares reset, so no
//    byte is considered sent; requester must resend whole message.
//  - busy = |grant; grant one-hot or zero at all times.
// TESTING
//  1 req[2]=1, data 0x41, last=1 -> next clk tx_start=1, tx_din=0x41, ack=0100 (1 clk);
//    after tx_done_tick grant=0, busy=0.
//  2 ptr=1, req=1001 simultaneously, all single-byte -> requester 3 served, then 0; ptr=1 after.
//  3 req[1] 3-byte msg 0x0D,0x15,0x22(last) with req[0] held high -> bytes of 1 sent
//    back-to-back, ack[0] only after 0x22 done; exactly one tx_start per tx_done_tick.
//  4 req[2] drops after first non-last byte for HOLD_MAX cycles -> abort pulse, grant
//    released, pending req[3] granted next clk; reassert before timeout -> resumes, no abort.
//  5 reset pulsed while in WAIT -> all outputs 0 same cycle; after release, fresh arbitration from ptr 0.
//  6 spurious tx_done_tick in IDLE and HOLD -> no state change, no tx_start, no ack.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer among NREQ byte streams.
// A granted requester keeps the line until its 'last' byte is sent or it idles past HOLD_MAX.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests starting at ptr
// SEND  | one-cycle tx_start/ack pulse for the latched byte
// WAIT  | byte in flight on uart_tx; waiting for tx_done_tick
// HOLD  | owner mid-message with no byte ready; hold counter running
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              abort,
    output logic              tx_start,
    output logic [7:0]        tx_din,
    input  logic              tx_done_tick
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   idx;
    logic            last_r;
    logic [CW-1:0]   hold_cnt;

    logic [IW-1:0]   hi_idx;
    logic [IW-1:0]   lo_idx;
    logic            hi_found;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic [7:0]      pick_data;
    logic            pick_last;
    logic [NREQ-1:0] idx_onehot;
    logic [7:0]      idx_data;
    logic            idx_req;
    logic            idx_last;
    logic [IW-1:0]   nxt_ptr;

    // First set request at or above ptr wins; otherwise wrap to the lowest set request.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i] && (IW'(i) >= ptr)) begin
                hi_found = 1'b1;
                hi_idx   = IW'(i);
            end
            if (req[i]) begin
                lo_idx = IW'(i);
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        pick_onehot = '0;
        pick_data   = '0;
        pick_last   = 1'b0;
        idx_onehot  = '0;
        idx_data    = '0;
        idx_req     = 1'b0;
        idx_last    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_onehot[i] = 1'b1;
                pick_data      = req_data[8*i +: 8];
                pick_last      = req_last[i];
            end
            if (idx == IW'(i)) begin
                idx_onehot[i] = 1'b1;
                idx_data      = req_data[8*i +: 8];
                idx_req       = req[i];
                idx_last      = req_last[i];
            end
        end
    end

    assign nxt_ptr = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
    assign busy    = |grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            idx      <= '0;
            last_r   <= 1'b0;
            hold_cnt <= '0;
            grant    <= '0;
            ack      <= '0;
            abort    <= 1'b0;
            tx_start <= 1'b0;
            tx_din   <= '0;
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            abort    <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        idx      <= pick_idx;
                        tx_din   <= pick_data;
                        last_r   <= pick_last;
                        grant    <= pick_onehot;
                        ack      <= pick_onehot;
                        tx_start <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (tx_done_tick) begin
                        if (last_r) begin
                            grant <= '0;
                            ptr   <= nxt_ptr;
                            state <= IDLE;
                        end else if (idx_req) begin
                            tx_din   <= idx_data;
                            last_r   <= idx_last;
                            ack      <= idx_onehot;
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end else begin
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (idx_req) begin
                        tx_din   <= idx_data;
                        last_r   <= idx_last;
                        ack      <= idx_onehot;
                        tx_start <= 1'b1;
                        state    <= SEND;
                    end else if (hold_cnt == CW'(HOLD_MAX - 1)) begin
                        abort <= 1'b1;
                        grant <= '0;
                        ptr   <= nxt_ptr;
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; tx_done_tick is driven by hand in place of a uart_tx.
module tb_uart_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int HOLD_MAX = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              abort;
    logic              tx_start;
    logic [7:0]        tx_din;
    logic              tx_done_tick;

    int errors = 0;
    int checks = 0;
    int n_start = 0;
    int n_abort = 0;
    int snap;

    uart_tx_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .req_last     (req_last),
        .ack          (ack),
        .grant        (grant),
        .busy         (busy),
        .abort        (abort),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_start === 1'b1) n_start++;
        if (abort === 1'b1) n_abort++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic done_pulse();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic set_byte(input int k, input logic [7:0] v, input logic l);
        req_data[8*k +: 8] = v;
        req_last[k]        = l;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        req          = '0;
        req_data     = '0;
        req_last     = '0;
        tx_done_tick = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_grant", grant, 0);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_abort", abort, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_din", tx_din, 0);

        // single-byte message from requester 2
        req = 4'b0100;
        set_byte(2, 8'h41, 1'b1);
        tick();
        check("t1_tx_start", tx_start, 1);
        check("t1_tx_din", tx_din, 8'h41);
        check("t1_ack", ack, 4'b0100);
        check("t1_grant", grant, 4'b0100);
        req = 4'b0000;
        tick();
        check("t1_start_width", tx_start, 0);
        check("t1_ack_width", ack, 0);
        check("t1_busy_wait", busy, 1);
        tick();
        done_pulse();
        check("t1_grant_rel", grant, 0);
        check("t1_busy_rel", busy, 0);

        // bring ptr to 1 by serving requester 0 (ptr was 3 after requester 2)
        req = 4'b0001;
        set_byte(0, 8'h10, 1'b1);
        tick();
        check("t2_pre_grant", grant, 4'b0001);
        req = 4'b0000;
        tick();
        done_pulse();
        // ptr=1, req 0 and 3 together -> 3 first, then 0
        req = 4'b1001;
        set_byte(3, 8'h33, 1'b1);
        set_byte(0, 8'h30, 1'b1);
        tick();
        check("t2_grant3", grant, 4'b1000);
        check("t2_din3", tx_din, 8'h33);
        check("t2_ack3", ack, 4'b1000);
        req = 4'b0001;
        tick();
        done_pulse();
        check("t2_idle", grant, 0);
        tick();
        check("t2_grant0", grant, 4'b0001);
        check("t2_din0", tx_din, 8'h30);
        req = 4'b0000;
        tick();
        done_pulse();
        // ptr should be 1: req 0 and 1 -> 1 wins
        req = 4'b0011;
        set_byte(1, 8'h11, 1'b1);
        tick();
        check("t2_ptr1", grant, 4'b0010);
        req = 4'b0000;
        tick();
        done_pulse();

        // 3-byte message from requester 1 while requester 0 waits
        snap = n_start;
        req = 4'b0010;
        set_byte(1, 8'h0D, 1'b0);
        tick();
        check("t3_b0_din", tx_din, 8'h0D);
        check("t3_b0_ack", ack, 4'b0010);
        req = 4'b0011;
        set_byte(0, 8'h55, 1'b1);
        tick();
        set_byte(1, 8'h15, 1'b0);
        check("t3_wait_nostart", tx_start, 0);
        done_pulse();
        check("t3_b1_start", tx_start, 1);
        check("t3_b1_din", tx_din, 8'h15);
        check("t3_b1_ack", ack, 4'b0010);
        check("t3_b1_grant", grant, 4'b0010);
        tick();
        set_byte(1, 8'h22, 1'b1);
        done_pulse();
        check("t3_b2_din", tx_din, 8'h22);
        check("t3_b2_ack", ack, 4'b0010);
        tick();
        req = 4'b0001;
        check("t3_no_ack0", ack, 0);
        done_pulse();
        check("t3_released", grant, 0);
        check("t3_start_count", n_start - snap, 3);
        tick();
        check("t3_grant0", grant, 4'b0001);
        check("t3_din0", tx_din, 8'h55);
        check("t3_ack0", ack, 4'b0001);
        req = 4'b0000;
        tick();
        done_pulse();

        // hold timeout: requester 2 stalls, requester 3 pending (ptr=1)
        snap = n_abort;
        req = 4'b0100;
        set_byte(2, 8'hA1, 1'b0);
        tick();
        check("t4_grant2", grant, 4'b0100);
        req = 4'b1000;
        set_byte(3, 8'hB3, 1'b1);
        tick();
        done_pulse();
        check("t4_hold_grant", grant, 4'b0100);
        check("t4_hold_nostart", tx_start, 0);
        repeat (HOLD_MAX - 1) tick();
        check("t4_pre_abort", abort, 0);
        check("t4_pre_abort_grant", grant, 4'b0100);
        tick();
        check("t4_abort", abort, 1);
        check("t4_abort_grant", grant, 0);
        check("t4_abort_busy", busy, 0);
        tick();
        check("t4_abort_width", abort, 0);
        check("t4_grant3", grant, 4'b1000);
        check("t4_din3", tx_din, 8'hB3);
        check("t4_abort_count", n_abort - snap, 1);
        req = 4'b0000;
        tick();
        done_pulse();

        // reassert before timeout resumes without abort (ptr=0)
        snap = n_abort;
        req = 4'b0100;
        set_byte(2, 8'hA2, 1'b0);
        tick();
        req = 4'b0000;
        tick();
        done_pulse();
        repeat (3) tick();
        req = 4'b0100;
        set_byte(2, 8'hA3, 1'b1);
        tick();
        check("t4r_start", tx_start, 1);
        check("t4r_din", tx_din, 8'hA3);
        check("t4r_grant", grant, 4'b0100);
        req = 4'b0000;
        tick();
        done_pulse();
        check("t4r_no_abort", n_abort - snap, 0);

        // spurious tx_done_tick in IDLE then in HOLD (ptr=3)
        snap = n_start;
        done_pulse();
        check("t6_idle_start", tx_start, 0);
        check("t6_idle_ack", ack, 0);
        check("t6_idle_grant", grant, 0);
        req = 4'b0010;
        set_byte(1, 8'hC1, 1'b0);
        tick();
        check("t6_grant1", grant, 4'b0010);
        req = 4'b0000;
        tick();
        done_pulse();
        done_pulse();
        check("t6_hold_start", tx_start, 0);
        check("t6_hold_ack", ack, 0);
        check("t6_hold_grant", grant, 4'b0010);
        tick();
        check("t6_start_count", n_start - snap, 1);
        req = 4'b0010;
        set_byte(1, 8'hC2, 1'b1);
        tick();
        check("t6_resume_din", tx_din, 8'hC2);
        check("t6_resume_ack", ack, 4'b0010);
        req = 4'b0000;
        tick();
        done_pulse();

        // reset while in WAIT (ptr=2)
        req = 4'b0001;
        set_byte(0, 8'hD0, 1'b1);
        tick();
        req = 4'b0000;
        tick();
        check("t5_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("t5_grant", grant, 0);
        check("t5_busy", busy, 0);
        check("t5_tx_din", tx_din, 0);
        check("t5_tx_start", tx_start, 0);
        check("t5_ack", ack, 0);
        check("t5_abort", abort, 0);
        tick();
        reset = 1'b0;
        req = 4'b1010;
        set_byte(1, 8'hE1, 1'b1);
        set_byte(3, 8'hE3, 1'b1);
        tick();
        check("t5_fresh_grant", grant, 4'b0010);
        check("t5_fresh_din", tx_din, 8'hE1);
        req = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
